// File: rtl/inst_queue.sv
// inst_queue: 8-entry circular FWFT instruction queue, dual push from fetch, dual pop to issue.
module inst_queue (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        push_first_valid,
  input  logic        push_second_valid,
  input  logic [31:0] push_pc_first,
  input  logic [31:0] push_pc_second,
  input  logic [31:0] push_instr_first,
  input  logic [31:0] push_instr_second,
  input  logic [1:0]  pop_cnt,
  output logic        first_valid,
  output logic        second_valid,
  output logic [31:0] pc_first_q,
  output logic [31:0] pc_second_q,
  output logic [31:0] instr_first_q,
  output logic [31:0] instr_second_q,
  output logic        queue_ready,
  output logic [3:0]  count
);
  logic [31:0] r_pc [8];
  logic [31:0] r_instr [8];
  logic [2:0]  r_head, r_tail;
  logic [3:0]  r_count;
  logic [3:0]  w_push_n, w_pop_req, w_pop_n;
  logic [2:0]  w_head1, w_tail1;
  always_comb begin
    queue_ready  = r_count <= 4'd6;
    w_push_n     = (queue_ready && push_first_valid) ? (push_second_valid ? 4'd2 : 4'd1) : 4'd0;
    w_pop_req    = pop_cnt[1] ? 4'd2 : {3'd0, pop_cnt[0]};
    w_pop_n      = (w_pop_req > r_count) ? r_count : w_pop_req;
    w_head1      = r_head + 3'd1;
    w_tail1      = r_tail + 3'd1;
    count        = r_count;
    first_valid  = r_count >= 4'd1;
    second_valid = r_count >= 4'd2;
    pc_first_q     = first_valid  ? r_pc[r_head]     : 32'h0;
    instr_first_q  = first_valid  ? r_instr[r_head]  : 32'h0;
    pc_second_q    = second_valid ? r_pc[w_head1]    : 32'h0;
    instr_second_q = second_valid ? r_instr[w_head1] : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_head  <= 3'd0;
      r_tail  <= 3'd0;
      r_count <= 4'd0;
    end else begin
      r_head  <= r_head + w_pop_n[2:0];
      r_tail  <= r_tail + w_push_n[2:0];
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end
  // Storage is not reset; validity is tracked purely by r_count.
  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      if (w_push_n != 4'd0) begin
        r_pc[r_tail]    <= push_pc_first;
        r_instr[r_tail] <= push_instr_first;
      end
      if (w_push_n == 4'd2) begin
        r_pc[w_tail1]    <= push_pc_second;
        r_instr[w_tail1] <= push_instr_second;
      end
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed and random checks of inst_queue against a queue-based model.
module tb_inst_queue;
  logic        clk = 1'b0;
  logic        resetn, flush, push_first_valid, push_second_valid;
  logic [31:0] push_pc_first, push_pc_second, push_instr_first, push_instr_second;
  logic [1:0]  pop_cnt;
  logic        first_valid, second_valid, queue_ready;
  logic [31:0] pc_first_q, pc_second_q, instr_first_q, instr_second_q;
  logic [3:0]  count;
  int tests = 0, fails = 0;
  logic [63:0] mq[$];

  always #5 clk = ~clk;

  inst_queue dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .push_first_valid(push_first_valid), .push_second_valid(push_second_valid),
    .push_pc_first(push_pc_first), .push_pc_second(push_pc_second),
    .push_instr_first(push_instr_first), .push_instr_second(push_instr_second),
    .pop_cnt(pop_cnt), .first_valid(first_valid), .second_valid(second_valid),
    .pc_first_q(pc_first_q), .pc_second_q(pc_second_q),
    .instr_first_q(instr_first_q), .instr_second_q(instr_second_q),
    .queue_ready(queue_ready), .count(count)
  );

  function automatic logic [31:0] iw(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n = mq.size();
    chk("count", {28'd0, count}, n);
    chk("first_valid", {31'd0, first_valid}, n >= 1);
    chk("second_valid", {31'd0, second_valid}, n >= 2);
    chk("queue_ready", {31'd0, queue_ready}, n <= 6);
    chk("pc_first", pc_first_q, n >= 1 ? mq[0][63:32] : 32'h0);
    chk("instr_first", instr_first_q, n >= 1 ? mq[0][31:0] : 32'h0);
    chk("pc_second", pc_second_q, n >= 2 ? mq[1][63:32] : 32'h0);
    chk("instr_second", instr_second_q, n >= 2 ? mq[1][31:0] : 32'h0);
  endtask

  task automatic step(input bit rn, fl, pf, ps, input logic [31:0] p1, p2, input logic [1:0] pc);
    int pn, qn;
    resetn = rn; flush = fl; push_first_valid = pf; push_second_valid = ps;
    push_pc_first = p1; push_pc_second = p2;
    push_instr_first = iw(p1); push_instr_second = iw(p2); pop_cnt = pc;
    @(posedge clk);
    if (!rn || fl) mq.delete();
    else begin
      qn = (pc == 2'd3) ? 2 : int'(pc);
      if (qn > mq.size()) qn = mq.size();
      pn = (mq.size() <= 6 && pf) ? (ps ? 2 : 1) : 0;
      repeat (qn) void'(mq.pop_front());
      if (pn >= 1) mq.push_back({p1, iw(p1)});
      if (pn == 2) mq.push_back({p2, iw(p2)});
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic rst();
    step(0, 0, 1, 1, 32'h1, 32'h2, 2'd0);
  endtask

  task automatic push2(input logic [31:0] p, input logic [1:0] pc);
    step(1, 0, 1, 1, p, p + 32'd4, pc);
  endtask

  initial begin
    logic [31:0] pcv;
    rst();
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, queue_ready}, 32'd1);
    chk("rst_pc_first", pc_first_q, 32'h0);
    // first pair after reset
    push2(32'hBFC0_0000, 2'd0);
    chk("pair_count", {28'd0, count}, 32'd2);
    chk("pair_pc0", pc_first_q, 32'hBFC0_0000);
    chk("pair_pc1", pc_second_q, 32'hBFC0_0004);
    chk("pair_v2", {31'd0, second_valid}, 32'd1);
    // fill to 8, then a dropped push
    push2(32'hBFC0_0008, 2'd0);
    push2(32'hBFC0_0010, 2'd0);
    chk("six_ready", {31'd0, queue_ready}, 32'd1);
    push2(32'hBFC0_0018, 2'd0);
    chk("full_count", {28'd0, count}, 32'd8);
    chk("full_ready", {31'd0, queue_ready}, 32'd0);
    push2(32'hDEAD_0000, 2'd0);
    chk("drop_count", {28'd0, count}, 32'd8);
    chk("drop_head", pc_first_q, 32'hBFC0_0000);
    // pop while full; push not accepted that cycle
    push2(32'hDEAD_1000, 2'd2);
    chk("fullpop_count", {28'd0, count}, 32'd6);
    chk("fullpop_head", pc_first_q, 32'hBFC0_0008);
    // count=1, push pair + pop 2 -> pop only 1
    rst();
    step(1, 0, 1, 0, 32'h100, 32'h0, 2'd0);
    push2(32'h200, 2'd2);
    chk("c1_count", {28'd0, count}, 32'd2);
    chk("c1_head", pc_first_q, 32'h200);
    chk("c1_instr", instr_first_q, iw(32'h200));
    // push from empty with pop request
    rst();
    push2(32'h300, 2'd3);
    chk("empty_pp_count", {28'd0, count}, 32'd2);
    // sustained pair in / pair out wraps pointers
    rst();
    pcv = 32'h1000;
    push2(pcv, 2'd0);
    for (int i = 0; i < 10; i++) begin
      pcv += 32'd8;
      push2(pcv, 2'd2);
    end
    chk("wrap_count", {28'd0, count}, 32'd2);
    chk("wrap_head", pc_first_q, 32'h1050);
    // flush beats push and pop
    rst();
    push2(32'h400, 2'd0);
    push2(32'h408, 2'd0);
    step(1, 0, 1, 0, 32'h410, 32'h0, 2'd0);
    chk("c5_count", {28'd0, count}, 32'd5);
    step(1, 1, 1, 1, 32'h500, 32'h504, 2'd1);
    chk("flush_count", {28'd0, count}, 32'd0);
    chk("flush_v1", {31'd0, first_valid}, 32'd0);
    chk("flush_pc", pc_first_q, 32'h0);
    chk("flush_ready", {31'd0, queue_ready}, 32'd1);
    // mid-operation reset
    push2(32'h600, 2'd0);
    push2(32'h608, 2'd0);
    push2(32'h610, 2'd0);
    rst();
    chk("midrst_count", {28'd0, count}, 32'd0);
    push2(32'h700, 2'd0);
    chk("midrst_push_count", {28'd0, count}, 32'd2);
    chk("midrst_push_head", pc_first_q, 32'h700);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom, $urandom, 2'($urandom_range(0, 3)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
